acc_seq: RTL and testbench

ACC_SEQ -- requirements
Module: acc_seq

---
 rtl/acc_pkg.sv | 29 ++
 rtl/acc_seq_if.sv | 48 ++++
 rtl/acc_mul_stage.sv | 40 ++++
 rtl/acc_seq.sv | 141 ++++++++++++++
 tb/tb_acc_seq.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared types and widths for the accumulate sequencer.
// ACC_SEQ_BIAS_EN adds the LOAD state used for the bias preload.
package acc_pkg;

    localparam int unsigned ACC_W = 16;
    localparam int unsigned OP_W  = 8;

`ifdef ACC_SEQ_BIAS_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LOAD  = 3'd2,
        S_ACC   = 3'd3,
        S_FLUSH = 3'd4,
        S_CAP   = 3'd5,
        S_OUT   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ACC   = 3'd3,
        S_FLUSH = 3'd4,
        S_CAP   = 3'd5,
        S_OUT   = 3'd6
    } state_t;
`endif

endpackage

// File: rtl/acc_seq_if.sv
// Job, operand, accumulator and result signals of acc_seq.
// ACC_SEQ_BIAS_EN adds the bias input.
interface acc_seq_if #(
    parameter int unsigned LEN_W = 8
);
    import acc_pkg::*;

    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             op_vld;
    logic             op_rdy;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic             acc_clr;
    logic             acc_vld;
    logic             load_vld;
    logic [ACC_W-1:0] acc_data;
    logic [ACC_W-1:0] load_data;
    logic [ACC_W-1:0] acc_q16;
    logic [OP_W-1:0]  acc_q8;
    logic             res_vld;
    logic             res_rdy;
    logic [ACC_W-1:0] res_int16;
    logic [OP_W-1:0]  res_int8;
`ifdef ACC_SEQ_BIAS_EN
    logic [ACC_W-1:0] bias;
`endif

    modport master (
`ifdef ACC_SEQ_BIAS_EN
        output bias,
`endif
        output start, len, op_vld, op_a, op_b, acc_q16, acc_q8, res_rdy,
        input  busy, op_rdy, acc_clr, acc_vld, load_vld, acc_data, load_data,
               res_vld, res_int16, res_int8
    );

    modport slave (
`ifdef ACC_SEQ_BIAS_EN
        input  bias,
`endif
        input  start, len, op_vld, op_a, op_b, acc_q16, acc_q8, res_rdy,
        output busy, op_rdy, acc_clr, acc_vld, load_vld, acc_data, load_data,
               res_vld, res_int16, res_int8
    );

endinterface

// File: rtl/acc_mul_stage.sv
// Registered signed 8x8 multiply; one product per accepted beat, one cycle later.
module acc_mul_stage
    import acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  i_op_a,
    input  logic [OP_W-1:0]  i_op_b,
    input  logic             i_accept,
    output logic             o_acc_vld,
    output logic [ACC_W-1:0] o_acc_data
);

    logic signed [ACC_W-1:0] w_a_ext;
    logic signed [ACC_W-1:0] w_b_ext;
    logic signed [ACC_W-1:0] w_prod;
    logic                    r_acc_vld;
    logic        [ACC_W-1:0] r_acc_data;

    // Sign-extend first so the 16-bit product is exact for every int8 pair
    assign w_a_ext = {{(ACC_W-OP_W){i_op_a[OP_W-1]}}, i_op_a};
    assign w_b_ext = {{(ACC_W-OP_W){i_op_b[OP_W-1]}}, i_op_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc_vld  <= 1'b0;
            r_acc_data <= '0;
        end else begin
            r_acc_vld <= i_accept;
            if (i_accept) begin
                r_acc_data <= w_prod;
            end
        end
    end

    assign o_acc_vld  = r_acc_vld;
    assign o_acc_data = r_acc_data;

endmodule

// File: rtl/acc_seq.sv
// Sequencer feeding signed products to an external accumulator and capturing its result.
// ACC_SEQ_BIAS_EN inserts a one-cycle bias preload (LOAD) after the clear.
module acc_seq
    import acc_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    acc_seq_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] w_count_inc;
    logic             w_accept;
    logic             w_last;
    logic             w_len_zero;
    logic             r_busy;
    logic             r_op_rdy;
    logic             r_acc_clr;
    logic             r_res_vld;
    logic [ACC_W-1:0] r_res_int16;
    logic [OP_W-1:0]  r_res_int8;
    logic             w_acc_vld;
    logic [ACC_W-1:0] w_acc_data;
`ifdef ACC_SEQ_BIAS_EN
    logic [ACC_W-1:0] r_bias;
    logic             r_load_vld;
    logic [ACC_W-1:0] r_load_data;
`endif

    assign w_accept    = r_op_rdy & bus.op_vld;
    assign w_count_inc = r_count + LEN_W'(1);
    assign w_last      = (w_count_inc == r_len);
    assign w_len_zero  = (r_len == LEN_W'(0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_CLR;
`ifdef ACC_SEQ_BIAS_EN
            S_CLR:   w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = w_len_zero ? S_FLUSH : S_ACC;
`else
            S_CLR:   w_state_nxt = w_len_zero ? S_FLUSH : S_ACC;
`endif
            S_ACC:   if (w_accept && w_last) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_CAP;
            S_CAP:   w_state_nxt = S_OUT;
            S_OUT:   if (r_res_vld && bus.res_rdy) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they align with r_state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_op_rdy    <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_res_vld   <= 1'b0;
            r_len       <= '0;
            r_count     <= '0;
            r_res_int16 <= '0;
            r_res_int8  <= '0;
        end else begin
            r_busy    <= (w_state_nxt != S_IDLE);
            r_op_rdy  <= (w_state_nxt == S_ACC);
            r_acc_clr <= (w_state_nxt == S_CLR);
            r_res_vld <= (w_state_nxt == S_OUT);
            if (r_state == S_IDLE && bus.start) begin
                r_len <= bus.len;
            end
            if (r_state == S_CLR) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= w_count_inc;
            end
            if (r_state == S_CAP) begin
                r_res_int16 <= bus.acc_q16;
                r_res_int8  <= bus.acc_q8;
            end
        end
    end

`ifdef ACC_SEQ_BIAS_EN
    // Bias is latched with the job; load_data only moves when LOAD is entered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bias      <= '0;
            r_load_vld  <= 1'b0;
            r_load_data <= '0;
        end else begin
            r_load_vld <= (w_state_nxt == S_LOAD);
            if (r_state == S_IDLE && bus.start) begin
                r_bias <= bus.bias;
            end
            if (w_state_nxt == S_LOAD) begin
                r_load_data <= r_bias;
            end
        end
    end

    assign bus.load_vld  = r_load_vld;
    assign bus.load_data = r_load_data;
`else
    assign bus.load_vld  = 1'b0;
    assign bus.load_data = '0;
`endif

    acc_mul_stage u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_op_a     (bus.op_a),
        .i_op_b     (bus.op_b),
        .i_accept   (w_accept),
        .o_acc_vld  (w_acc_vld),
        .o_acc_data (w_acc_data)
    );

    assign bus.busy      = r_busy;
    assign bus.op_rdy    = r_op_rdy;
    assign bus.acc_clr   = r_acc_clr;
    assign bus.acc_vld   = w_acc_vld;
    assign bus.acc_data  = w_acc_data;
    assign bus.res_vld   = r_res_vld;
    assign bus.res_int16 = r_res_int16;
    assign bus.res_int8  = r_res_int8;

endmodule

// File: tb/tb_acc_seq.sv
// Directed bench for acc_seq with a saturating int16 accumulator model in the loop.
// Build with ACC_SEQ_BIAS_EN to also exercise the bias preload.
module tb_acc_seq;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   n_accvld;
    int   n_clr;
    logic [15:0] cur_bias;
    logic signed [15:0] r_acc;

    acc_seq_if #(.LEN_W(8)) bus ();

    acc_seq #(.LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] sat16(input int v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    function automatic logic [7:0] sat8(input logic signed [15:0] v);
        if (v > 16'sd127)  return 8'h7F;
        if (v < -16'sd128) return 8'h80;
        return v[7:0];
    endfunction

    // Accumulator model: clear, preload, saturating add
    always_ff @(posedge clk) begin
        if (!rst_n)            r_acc <= '0;
        else if (bus.acc_clr)  r_acc <= '0;
        else if (bus.load_vld) r_acc <= bus.load_data;
        else if (bus.acc_vld)  r_acc <= sat16(int'(r_acc) + int'($signed(bus.acc_data)));
    end
    assign bus.acc_q16 = r_acc;
    assign bus.acc_q8  = sat8(r_acc);

    always @(posedge clk) begin
        if (bus.acc_vld === 1'b1) n_accvld++;
        if (bus.acc_clr === 1'b1) n_clr++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input int n);
        bus.start = 1'b1;
        bus.len   = 8'(n);
        tick();
        bus.start = 1'b0;
        check("clr_pulse", {bus.acc_clr, bus.busy}, 2'b11);
`ifdef ACC_SEQ_BIAS_EN
        tick();
        check("load_vld", {bus.load_vld, bus.acc_clr}, 2'b10);
        check("load_data", bus.load_data, cur_bias);
`endif
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic [15:0] prod);
        int k;
        bus.op_vld = 1'b1;
        bus.op_a   = a;
        bus.op_b   = b;
        k = 0;
        while (bus.op_rdy !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) check("op_rdy_timeout", bus.op_rdy, 1);
        tick();
        bus.op_vld = 1'b0;
        check("acc_vld", bus.acc_vld, 1);
        check("acc_data", bus.acc_data, prod);
    endtask

    task automatic wait_res();
        int k;
        k = 0;
        while (bus.res_vld !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) check("res_vld_timeout", bus.res_vld, 1);
    endtask

    task automatic finish_job(input logic [15:0] e16, input logic [7:0] e8);
        wait_res();
        check("res_int16", bus.res_int16, e16);
        check("res_int8", bus.res_int8, e8);
        bus.res_rdy = 1'b1;
        tick();
        bus.res_rdy = 1'b0;
        check("idle_after_hs", {bus.res_vld, bus.busy}, 2'b00);
    endtask

    initial begin
        int c0;
        int v0;
        n_vec = 0;
        n_err = 0;
        n_accvld = 0;
        n_clr = 0;
        cur_bias = 16'h0000;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.len = '0;
        bus.op_vld = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.res_rdy = 1'b0;
`ifdef ACC_SEQ_BIAS_EN
        bus.bias = 16'h0000;
`endif
        tick();
        tick();
        check("reset_ctrl", {bus.busy, bus.op_rdy, bus.acc_clr, bus.acc_vld, bus.load_vld, bus.res_vld}, 6'b0);
        check("reset_data", {bus.acc_data, bus.load_data}, 32'h0);
        check("reset_res", {bus.res_int16, bus.res_int8}, 24'h0);
        rst_n = 1'b1;
        tick();

        // Mixed-sign back-to-back beats
        start_job(3);
        send_beat(8'd2, 8'd3, 16'd6);
        send_beat(8'hFC, 8'd5, 16'hFFEC);
        send_beat(8'd127, 8'd127, 16'h3F01);
        check("flush_state", {bus.op_rdy, bus.busy}, 2'b01);
        finish_job(16'h3EF3, 8'h7F);

        // Accumulator saturation, started right after the previous handshake
        start_job(3);
        send_beat(8'd127, 8'd127, 16'h3F01);
        send_beat(8'd127, 8'd127, 16'h3F01);
        send_beat(8'd127, 8'd127, 16'h3F01);
        finish_job(16'h7FFF, 8'h7F);

        // Empty job: no products, single clear, result after four cycles
        c0 = n_clr;
        v0 = n_accvld;
        start_job(0);
        tick();
        tick();
        check("len0_res_early", bus.res_vld, 0);
        tick();
        check("len0_res_vld", bus.res_vld, 1);
        check("len0_accvld_cnt", 32'(n_accvld - v0), 0);
        check("len0_clr_cnt", 32'(n_clr - c0), 1);
        finish_job(16'h0000, 8'h00);

        // Operand gaps, ignored start while busy, delayed result acceptance
        c0 = n_clr;
        start_job(2);
        send_beat(8'd5, 8'hFA, 16'hFFE2);
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gap_acc_vld", {bus.acc_vld, bus.op_rdy}, 2'b01);
        end
        bus.start = 1'b0;
        send_beat(8'd7, 8'd8, 16'd56);
        wait_res();
        for (int i = 0; i < 5; i++) begin
            check("hold_res", {bus.res_vld, bus.res_int16, bus.res_int8}, {1'b1, 16'd26, 8'd26});
            tick();
        end
        finish_job(16'd26, 8'd26);
        check("gap_clr_cnt", 32'(n_clr - c0), 1);
        tick();
        check("stay_idle", bus.busy, 0);

`ifdef ACC_SEQ_BIAS_EN
        // Bias preload cancels the product
        cur_bias = 16'hFF9C;
        bus.bias = 16'hFF9C;
        start_job(1);
        send_beat(8'd10, 8'd10, 16'd100);
        finish_job(16'h0000, 8'h00);
        cur_bias = 16'h0000;
        bus.bias = 16'h0000;
`endif

        // Reset in the middle of a job, then a clean job
        start_job(4);
        send_beat(8'd2, 8'd2, 16'd4);
        rst_n = 1'b0;
        tick();
        check("midrst_ctrl", {bus.busy, bus.op_rdy, bus.acc_clr, bus.acc_vld, bus.load_vld, bus.res_vld}, 6'b0);
        check("midrst_data", {bus.acc_data, bus.load_data}, 32'h0);
        check("midrst_res", {bus.res_int16, bus.res_int8}, 24'h0);
        rst_n = 1'b1;
        v0 = n_accvld;
        tick();
        tick();
        check("midrst_no_accvld", 32'(n_accvld - v0), 0);
        start_job(1);
        send_beat(8'd3, 8'd3, 16'd9);
        finish_job(16'd9, 8'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
